// File: rtl/program_loader.sv
// Byte-stream loader for the instruction ROM: packs big-endian words, writes them
// from address 0 upward, verifies a trailing XOR checksum and gates the CPU hold.
module program_loader #(
  parameter int ADDR_W    = 9,
  parameter int MAX_WORDS = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  localparam int IW = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

  state_t        state;
  logic [1:0]    byte_cnt;
  logic [IW-1:0] word_idx;
  logic [IW-1:0] last_idx;
  logic [7:0]    checksum;
  logic [23:0]   asm_hi;

  logic xfer;
  logic start_ok;
  assign xfer     = in_valid & in_ready;
  assign start_ok = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_hold  <= 1'b1;
      byte_cnt  <= '0;
      word_idx  <= '0;
      last_idx  <= '0;
      checksum  <= '0;
      asm_hi    <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        checksum <= '0;
        byte_cnt <= '0;
        word_idx <= '0;
        last_idx <= IW'(len - 8'd1);
        cpu_hold <= 1'b1;
        if (len == 8'd0) begin
          state    <= CHECK;
          in_ready <= 1'b1;
          busy     <= 1'b1;
          done     <= 1'b0;
          err      <= 1'b0;
        end else if (int'(len) > MAX_WORDS) begin
          // Oversized program: reject outright without touching memory.
          state    <= DONE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          err      <= 1'b1;
        end else begin
          state    <= LOAD;
          in_ready <= 1'b1;
          busy     <= 1'b1;
          done     <= 1'b0;
          err      <= 1'b0;
        end
      end else begin
        case (state)
          LOAD: begin
            if (xfer) begin
              checksum <= checksum ^ in_data;
              byte_cnt <= byte_cnt + 2'd1;
              case (byte_cnt)
                2'd0: asm_hi[23:16] <= in_data;
                2'd1: asm_hi[15:8]  <= in_data;
                2'd2: asm_hi[7:0]   <= in_data;
                default: begin
                  // Word complete: the write lands next cycle while a new word starts filling.
                  mem_we    <= 1'b1;
                  mem_wdata <= {asm_hi, in_data};
                  mem_addr  <= {word_idx, 2'b00};
                  word_idx  <= word_idx + 1'b1;
                  if (word_idx == last_idx) state <= CHECK;
                end
              endcase
            end
          end
          CHECK: begin
            if (xfer) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              err      <= (in_data != checksum);
              cpu_hold <= (in_data != checksum);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: hand-computed word writes, checksum outcomes,
// invalid lengths, stalls, ignored starts and mid-load reset.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  len_in;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  int checks   = 0;
  int failures = 0;
  int ready_cycles = 0;
  logic [8:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  program_loader #(.ADDR_W(9), .MAX_WORDS(128)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len_in),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  // Every negedge with mem_we high is one write pulse.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (in_ready) ready_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic do_start(input logic [7:0] l);
    start  = 1'b1;
    len_in = l;
    @(negedge clk);
    start  = 1'b0;
    len_in = 8'd0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1'b0;
    repeat (gap) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Two-word program 82102005 / 8A00A001 whose XOR checksum is 9C.
  task automatic load2(input string tag, input logic [7:0] cks, input int maxgap,
                       input bit inject_start);
    logic [7:0] s[8] = '{8'h82, 8'h10, 8'h20, 8'h05, 8'h8A, 8'h00, 8'hA0, 8'h01};
    clear_log();
    do_start(8'd2);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (inject_start && i == 3) do_start(8'd5);
      send(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
    send(cks, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_ready_end"}, 32'(in_ready), 32'd0);
    chk({tag, "_nwrites"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk({tag, "_addr0"}, 32'(wr_addr[0]), 32'h000);
      chk({tag, "_data0"}, wr_data[0], 32'h82102005);
      chk({tag, "_addr1"}, 32'(wr_addr[1]), 32'h004);
      chk({tag, "_data1"}, wr_data[1], 32'h8A00A001);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len_in = 8'd0; in_valid = 1'b0; in_data = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we",    32'(mem_we),   32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_done",  32'(done),     32'd0);
    chk("rst_err",   32'(err),      32'd0);
    chk("rst_hold",  32'(cpu_hold), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Good checksum, back-to-back bytes
    load2("s1", 8'h9C, 0, 1'b0);
    chk("s1_err",  32'(err),      32'd0);
    chk("s1_hold", 32'(cpu_hold), 32'd0);

    // Bad checksum: writes persist, CPU stays held
    load2("s2", 8'h9D, 0, 1'b0);
    chk("s2_err",  32'(err),      32'd1);
    chk("s2_hold", 32'(cpu_hold), 32'd1);

    // Random stalls with garbage data on idle cycles
    load2("s3", 8'h9C, 5, 1'b0);
    chk("s3_err",  32'(err),      32'd0);
    chk("s3_hold", 32'(cpu_hold), 32'd0);

    // Start pulsed mid-load is ignored
    load2("s6", 8'h9C, 0, 1'b1);
    chk("s6_err",  32'(err),      32'd0);
    chk("s6_hold", 32'(cpu_hold), 32'd0);

    // Zero-length program: only the checksum byte 00
    clear_log();
    do_start(8'd0);
    chk("s4_ready0", 32'(in_ready), 32'd1);
    send(8'h00, 0);
    chk("s4_done0",  32'(done),     32'd1);
    chk("s4_err0",   32'(err),      32'd0);
    chk("s4_hold0",  32'(cpu_hold), 32'd0);
    chk("s4_nwr0",   32'(wr_addr.size()), 32'd0);

    // Oversized length rejected the cycle after start
    ready_cycles = 0;
    do_start(8'd129);
    chk("s4_done129", 32'(done),     32'd1);
    chk("s4_err129",  32'(err),      32'd1);
    chk("s4_hold129", 32'(cpu_hold), 32'd1);
    repeat (4) @(negedge clk);
    chk("s4_ready129", 32'(ready_cycles), 32'd0);
    chk("s4_nwr129",   32'(wr_addr.size()), 32'd0);

    // Reset after 6 bytes of a 3-word load
    clear_log();
    do_start(8'd3);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    send(8'h44, 0); send(8'h55, 0); send(8'h66, 0);
    #2 reset = 1'b1;
    #1;
    chk("s5_rst_ready", 32'(in_ready), 32'd0);
    chk("s5_rst_busy",  32'(busy),     32'd0);
    chk("s5_rst_hold",  32'(cpu_hold), 32'd1);
    chk("s5_rst_wdata", mem_wdata,     32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("s5_nwr",   32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      chk("s5_addr0", 32'(wr_addr[0]), 32'h000);
      chk("s5_data0", wr_data[0], 32'h11223344);
    end

    // Reload one word after reset: restarts at address 0
    clear_log();
    do_start(8'd1);
    send(8'h01, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'h01, 0);
    chk("s5b_done", 32'(done),     32'd1);
    chk("s5b_err",  32'(err),      32'd0);
    chk("s5b_hold", 32'(cpu_hold), 32'd0);
    chk("s5b_nwr",  32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      chk("s5b_addr0", 32'(wr_addr[0]), 32'h000);
      chk("s5b_data0", wr_data[0], 32'h01000000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
